// File: rtl/alu_seq_pkg.sv
// Shared types and opcode constants for the sequential ALU.
package alu_seq_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_SH  = 3'd5;
  localparam logic [OP_W-1:0] OP_ROT = 3'd6;
  localparam logic [OP_W-1:0] OP_NOP = 3'd7;

  typedef enum logic [OP_W-1:0] {
    kADD = 3'd0,
    kSUB = 3'd1,
    kAND = 3'd2,
    kOR  = 3'd3,
    kXOR = 3'd4,
    kSH  = 3'd5,
    kROT = 3'd6,
    kNOP = 3'd7
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_seq_shifter.sv
// Loadable operand register with a one-bit-per-cycle shift/rotate step and step counter.
module alu_seq_shifter
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SAW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [SAW-1:0]   load_cnt,
  input  logic             load_left,
  input  logic             load_rot,
  input  logic             load_step,
  input  logic             advance,
  output logic [WIDTH-1:0] value,
  output logic [SAW-1:0]   cnt,
  output logic [WIDTH-1:0] next_value_c,
  output logic             shout_c,
  output logic             last_c
);

  logic left;
  logic rot;
  logic step;

  // One-bit step; a non-stepping load (non-shift op or zero amount) passes the value through.
  always_comb begin
    next_value_c = value;
    shout_c      = 1'b0;
    if (step) begin
      if (left) begin
        next_value_c = {value[WIDTH-2:0], rot ? value[WIDTH-1] : 1'b0};
        shout_c      = value[WIDTH-1];
      end else begin
        next_value_c = {rot ? value[0] : 1'b0, value[WIDTH-1:1]};
        shout_c      = value[0];
      end
    end
  end

  assign last_c = (cnt == SAW'(1));

  // Operand/counter register: load has priority over stepping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= '0;
      cnt   <= '0;
      left  <= 1'b0;
      rot   <= 1'b0;
      step  <= 1'b0;
    end else if (load) begin
      value <= load_value;
      cnt   <= load_cnt;
      left  <= load_left;
      rot   <= load_rot;
      step  <= load_step;
    end else if (advance) begin
      value <= next_value_c;
      cnt   <= cnt - SAW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with START/BUSY/DONE handshake and bit-serial shifts.
// Optional feature macro: ALU_ROT_EN enables opcode 6 as rotate (otherwise it acts as NOP).
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SAW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [OP_W-1:0]  OP,
  input  logic [WIDTH-1:0] INPUTA,
  input  logic [WIDTH-1:0] INPUTB,
  input  logic             SC_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] OUT,
  output logic             SC_OUT,
  output logic             ZERO
);

`ifdef ALU_ROT_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  alu_state_e       state;
  alu_op_e          op_q;
  logic [WIDTH-1:0] b_q;
  logic             sc_q;

  logic             accept_c;
  logic             is_shift_c;
  logic [SAW-1:0]   amt_c;
  logic             step_en_c;
  logic [SAW-1:0]   load_cnt_c;

  logic [WIDTH-1:0] a_val;
  logic [SAW-1:0]   cnt;
  logic [WIDTH-1:0] shift_val_c;
  logic             shout_c;
  logic             last_c;

  logic [WIDTH:0]   sum_c;
  logic [WIDTH:0]   dif_c;
  logic [WIDTH-1:0] res_c;
  logic             co_c;

  // Acceptance and load decode for the incoming request.
  always_comb begin
    accept_c   = START && !BUSY;
    is_shift_c = (OP == OP_SH) || (ROT_EN && (OP == OP_ROT));
    amt_c      = INPUTB[SAW:1];
    step_en_c  = is_shift_c && (amt_c != '0);
    load_cnt_c = step_en_c ? amt_c : SAW'(1);
  end

  alu_seq_shifter #(
    .WIDTH (WIDTH),
    .SAW   (SAW)
  ) u_shifter (
    .clk          (CLK),
    .rst_n        (RST_N),
    .load         (accept_c),
    .load_value   (INPUTA),
    .load_cnt     (load_cnt_c),
    .load_left    (INPUTB[0]),
    .load_rot     (OP == OP_ROT),
    .load_step    (step_en_c),
    .advance      (state == EXEC),
    .value        (a_val),
    .cnt          (cnt),
    .next_value_c (shift_val_c),
    .shout_c      (shout_c),
    .last_c       (last_c)
  );

  // Single-cycle arithmetic/logic result; the shifter register holds A unmodified for these ops.
  always_comb begin
    sum_c = {1'b0, a_val} + {1'b0, b_q} + (WIDTH+1)'(sc_q);
    dif_c = {1'b0, a_val} + {1'b0, ~b_q} + (WIDTH+1)'(sc_q);
    res_c = '0;
    co_c  = 1'b0;
    case (op_q)
      kADD: begin
        res_c = sum_c[WIDTH-1:0];
        co_c  = sum_c[WIDTH];
      end
      kSUB: begin
        res_c = dif_c[WIDTH-1:0];
        co_c  = dif_c[WIDTH];
      end
      kAND: res_c = a_val & b_q;
      kOR:  res_c = a_val | b_q;
      kXOR: res_c = a_val ^ b_q;
      kSH: begin
        res_c = shift_val_c;
        co_c  = shout_c;
      end
      kROT: begin
        res_c = ROT_EN ? shift_val_c : '0;
        co_c  = ROT_EN ? shout_c : 1'b0;
      end
      default: begin
        res_c = '0;
        co_c  = 1'b0;
      end
    endcase
  end

  // Control FSM and output registers; a request may be accepted on the same edge that completes one.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= IDLE;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      OUT    <= '0;
      SC_OUT <= 1'b0;
      ZERO   <= 1'b0;
      op_q   <= kNOP;
      b_q    <= '0;
      sc_q   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if ((state == EXEC) && last_c) begin
        OUT    <= res_c;
        SC_OUT <= co_c;
        ZERO   <= (res_c == '0);
        DONE   <= 1'b1;
        state  <= IDLE;
      end
      if (accept_c) begin
        state <= EXEC;
        op_q  <= alu_op_e'(OP);
        b_q   <= INPUTB;
        sc_q  <= SC_IN;
        BUSY  <= (load_cnt_c > SAW'(1));
      end else if ((state == EXEC) && !last_c) begin
        BUSY <= (cnt > SAW'(2));
      end else begin
        BUSY <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed scenarios plus randomized traffic vs a timeline model.
module tb_alu_seq;

  localparam int unsigned W   = 8;
  localparam int unsigned SAW = 3;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         START;
  logic [2:0]   OP;
  logic [W-1:0] INPUTA;
  logic [W-1:0] INPUTB;
  logic         SC_IN;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] OUT;
  logic         SC_OUT;
  logic         ZERO;

  int checks   = 0;
  int failures = 0;

  // Timeline model state
  int           edge_n    = 0;
  bit           pend      = 0;
  int           done_edge = 0;
  logic [W-1:0] p_out;
  logic         p_sc;
  logic [W-1:0] exp_out   = '0;
  logic         exp_sc    = 1'b0;
  logic         exp_zero  = 1'b0;
  logic         exp_done  = 1'b0;
  logic         exp_busy  = 1'b0;

  alu_seq #(.WIDTH(W)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .START  (START),
    .OP     (OP),
    .INPUTA (INPUTA),
    .INPUTB (INPUTB),
    .SC_IN  (SC_IN),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .OUT    (OUT),
    .SC_OUT (SC_OUT),
    .ZERO   (ZERO)
  );

  always #5 CLK = ~CLK;

  // Result and latency of one operation, straight from the opcode definitions.
  function automatic void ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, output logic [W-1:0] r, output logic sc, output int lat);
    int k;
    bit rot_en;
    logic [W:0] s;
    k = int'(b[SAW:1]);
`ifdef ALU_ROT_EN
    rot_en = 1;
`else
    rot_en = 0;
`endif
    r = '0;
    sc = 1'b0;
    lat = 1;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b} + (W+1)'(ci); r = s[W-1:0]; sc = s[W]; end
      3'd1: begin s = {1'b0, a} + {1'b0, ~b} + (W+1)'(ci); r = s[W-1:0]; sc = s[W]; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5, 3'd6: begin
        if (op == 3'd5 || rot_en) begin
          lat = (k == 0) ? 1 : k;
          if (k == 0) r = a;
          else if (b[0]) begin
            r  = (op == 3'd6) ? ((a << k) | (a >> (W - k))) : (a << k);
            sc = a[W-k];
          end else begin
            r  = (op == 3'd6) ? ((a >> k) | (a << (W - k))) : (a >> k);
            sc = a[k-1];
          end
        end
      end
      default: ;
    endcase
  endfunction

  // Drive one cycle of inputs, advance the timeline model across the edge, settle.
  task automatic drive_cycle(input logic rn, input logic st, input logic [2:0] op,
                             input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    int lat;
    RST_N = rn; START = st; OP = op; INPUTA = a; INPUTB = b; SC_IN = ci;
    @(posedge CLK);
    edge_n++;
    if (!rn) begin
      pend = 0; exp_busy = 0; exp_done = 0; exp_out = '0; exp_sc = 0; exp_zero = 0;
    end else begin
      exp_done = 0;
      if (pend && edge_n == done_edge) begin
        exp_out = p_out; exp_sc = p_sc; exp_zero = (p_out == '0); exp_done = 1; pend = 0;
      end
      if (st && !pend) begin
        ref_op(op, a, b, ci, p_out, p_sc, lat);
        pend = 1;
        done_edge = edge_n + lat;
      end
      exp_busy = pend && (edge_n <= done_edge - 2);
    end
    #1;
  endtask

  task automatic idle();
    drive_cycle(1'b1, 1'b0, 3'd7, '0, '0, 1'b0);
  endtask

  // Run idle cycles until DONE (bounded); n = edges waited, nb = cycles BUSY was seen high.
  task automatic wait_done(output int n, output int nb);
    n = 0;
    nb = int'(BUSY);
    while (!DONE && n < 20) begin
      idle();
      n++;
      if (!DONE && BUSY) nb++;
    end
  endtask

  task automatic test_reset();
    drive_cycle(1'b0, 1'b0, 3'd0, '0, '0, 1'b0);
    drive_cycle(1'b0, 1'b0, 3'd0, '0, '0, 1'b0);
    checks += 5;
    if (BUSY !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b want=0", BUSY); end
    if (DONE !== 1'b0)  begin failures++; $display("FAIL reset_done got=%b want=0", DONE); end
    if (OUT !== 8'h00)  begin failures++; $display("FAIL reset_out got=%h want=00", OUT); end
    if (SC_OUT !== 1'b0) begin failures++; $display("FAIL reset_sc got=%b want=0", SC_OUT); end
    if (ZERO !== 1'b0)  begin failures++; $display("FAIL reset_zero got=%b want=0", ZERO); end
    idle();
  endtask

  task automatic test_add_sub();
    int n, nb;
    drive_cycle(1'b1, 1'b1, 3'd0, 8'hF0, 8'h20, 1'b1);
    wait_done(n, nb);
    checks += 5;
    if (n != 1)         begin failures++; $display("FAIL add_lat got=%0d want=1", n); end
    if (nb != 0)        begin failures++; $display("FAIL add_busy got=%0d want=0", nb); end
    if (OUT !== 8'h11)  begin failures++; $display("FAIL add_out got=%h want=11", OUT); end
    if (SC_OUT !== 1'b1) begin failures++; $display("FAIL add_sc got=%b want=1", SC_OUT); end
    if (ZERO !== 1'b0)  begin failures++; $display("FAIL add_zero got=%b want=0", ZERO); end
    idle();
    drive_cycle(1'b1, 1'b1, 3'd1, 8'h05, 8'h05, 1'b1);
    wait_done(n, nb);
    checks += 4;
    if (n != 1)         begin failures++; $display("FAIL sub_lat got=%0d want=1", n); end
    if (OUT !== 8'h00)  begin failures++; $display("FAIL sub_out got=%h want=00", OUT); end
    if (SC_OUT !== 1'b1) begin failures++; $display("FAIL sub_sc got=%b want=1", SC_OUT); end
    if (ZERO !== 1'b1)  begin failures++; $display("FAIL sub_zero got=%b want=1", ZERO); end
    idle();
  endtask

  task automatic test_shift();
    int n, nb;
    drive_cycle(1'b1, 1'b1, 3'd5, 8'hB3, 8'h07, 1'b0);
    wait_done(n, nb);
    checks += 4;
    if (n != 3)         begin failures++; $display("FAIL shl_lat got=%0d want=3", n); end
    if (nb != 2)        begin failures++; $display("FAIL shl_busy got=%0d want=2", nb); end
    if (OUT !== 8'h98)  begin failures++; $display("FAIL shl_out got=%h want=98", OUT); end
    if (SC_OUT !== 1'b1) begin failures++; $display("FAIL shl_sc got=%b want=1", SC_OUT); end
    idle();
    drive_cycle(1'b1, 1'b1, 3'd5, 8'hB3, 8'h04, 1'b0);
    wait_done(n, nb);
    checks += 3;
    if (n != 2)         begin failures++; $display("FAIL shr_lat got=%0d want=2", n); end
    if (OUT !== 8'h2C)  begin failures++; $display("FAIL shr_out got=%h want=2c", OUT); end
    if (SC_OUT !== 1'b1) begin failures++; $display("FAIL shr_sc got=%b want=1", SC_OUT); end
    idle();
    drive_cycle(1'b1, 1'b1, 3'd5, 8'h5A, 8'h01, 1'b0);
    wait_done(n, nb);
    checks += 3;
    if (n != 1)         begin failures++; $display("FAIL sh0_lat got=%0d want=1", n); end
    if (OUT !== 8'h5A)  begin failures++; $display("FAIL sh0_out got=%h want=5a", OUT); end
    if (SC_OUT !== 1'b0) begin failures++; $display("FAIL sh0_sc got=%b want=0", SC_OUT); end
    idle();
  endtask

  task automatic test_busy_ignore();
    int n, nb;
    drive_cycle(1'b1, 1'b1, 3'd5, 8'h01, 8'h0F, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (BUSY !== 1'b1) begin failures++; $display("FAIL ign_busy%0d got=%b want=1", i, BUSY); end
      drive_cycle(1'b1, 1'b1, 3'd0, 8'hFF, 8'hFF, 1'b1);
    end
    wait_done(n, nb);
    checks += 4;
    if (n != 4)         begin failures++; $display("FAIL ign_lat got=%0d want=4", n); end
    if (OUT !== 8'h80)  begin failures++; $display("FAIL ign_out got=%h want=80", OUT); end
    if (SC_OUT !== 1'b0) begin failures++; $display("FAIL ign_sc got=%b want=0", SC_OUT); end
    if (ZERO !== 1'b0)  begin failures++; $display("FAIL ign_zero got=%b want=0", ZERO); end
    idle();
    checks++;
    if (DONE !== 1'b0) begin failures++; $display("FAIL ign_extra_done got=%b want=0", DONE); end
  endtask

  task automatic test_back_to_back();
    drive_cycle(1'b1, 1'b1, 3'd0, 8'h01, 8'h01, 1'b0);
    drive_cycle(1'b1, 1'b1, 3'd4, 8'h0F, 8'h05, 1'b0);
    checks += 2;
    if (DONE !== 1'b1) begin failures++; $display("FAIL b2b_done1 got=%b want=1", DONE); end
    if (OUT !== 8'h02) begin failures++; $display("FAIL b2b_out1 got=%h want=02", OUT); end
    drive_cycle(1'b1, 1'b1, 3'd2, 8'hFF, 8'h3C, 1'b0);
    checks += 2;
    if (DONE !== 1'b1) begin failures++; $display("FAIL b2b_done2 got=%b want=1", DONE); end
    if (OUT !== 8'h0A) begin failures++; $display("FAIL b2b_out2 got=%h want=0a", OUT); end
    idle();
    checks += 2;
    if (DONE !== 1'b1) begin failures++; $display("FAIL b2b_done3 got=%b want=1", DONE); end
    if (OUT !== 8'h3C) begin failures++; $display("FAIL b2b_out3 got=%h want=3c", OUT); end
    idle();
    checks++;
    if (DONE !== 1'b0) begin failures++; $display("FAIL b2b_done4 got=%b want=0", DONE); end
  endtask

  task automatic test_reset_mid();
    int seen;
    drive_cycle(1'b1, 1'b1, 3'd5, 8'hB3, 8'h0F, 1'b0);
    idle();
    idle();
    drive_cycle(1'b0, 1'b0, 3'd0, '0, '0, 1'b0);
    checks += 5;
    if (BUSY !== 1'b0)  begin failures++; $display("FAIL rmid_busy got=%b want=0", BUSY); end
    if (DONE !== 1'b0)  begin failures++; $display("FAIL rmid_done got=%b want=0", DONE); end
    if (OUT !== 8'h00)  begin failures++; $display("FAIL rmid_out got=%h want=00", OUT); end
    if (SC_OUT !== 1'b0) begin failures++; $display("FAIL rmid_sc got=%b want=0", SC_OUT); end
    if (ZERO !== 1'b0)  begin failures++; $display("FAIL rmid_zero got=%b want=0", ZERO); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      idle();
      if (DONE) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL rmid_late_done got=%0d want=0", seen); end
  endtask

  task automatic test_rot();
    int n, nb;
    drive_cycle(1'b1, 1'b1, 3'd6, 8'h81, 8'h03, 1'b0);
    wait_done(n, nb);
    checks += 4;
    if (n != 1) begin failures++; $display("FAIL rot_lat got=%0d want=1", n); end
`ifdef ALU_ROT_EN
    if (OUT !== 8'h03)  begin failures++; $display("FAIL rot_out got=%h want=03", OUT); end
    if (SC_OUT !== 1'b1) begin failures++; $display("FAIL rot_sc got=%b want=1", SC_OUT); end
    if (ZERO !== 1'b0)  begin failures++; $display("FAIL rot_zero got=%b want=0", ZERO); end
`else
    if (OUT !== 8'h00)  begin failures++; $display("FAIL rot_out got=%h want=00", OUT); end
    if (SC_OUT !== 1'b0) begin failures++; $display("FAIL rot_sc got=%b want=0", SC_OUT); end
    if (ZERO !== 1'b1)  begin failures++; $display("FAIL rot_zero got=%b want=1", ZERO); end
`endif
    idle();
  endtask

  task automatic test_random();
    logic rn, st;
    for (int i = 0; i < 600; i++) begin
      rn = ($urandom_range(0, 63) != 0);
      st = ($urandom_range(0, 1) == 1);
      drive_cycle(rn, st, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom));
      checks += 5;
      if (BUSY !== exp_busy) begin failures++; $display("FAIL rnd_busy@%0d got=%b want=%b", edge_n, BUSY, exp_busy); end
      if (DONE !== exp_done) begin failures++; $display("FAIL rnd_done@%0d got=%b want=%b", edge_n, DONE, exp_done); end
      if (OUT !== exp_out)   begin failures++; $display("FAIL rnd_out@%0d got=%h want=%h", edge_n, OUT, exp_out); end
      if (SC_OUT !== exp_sc) begin failures++; $display("FAIL rnd_sc@%0d got=%b want=%b", edge_n, SC_OUT, exp_sc); end
      if (ZERO !== exp_zero) begin failures++; $display("FAIL rnd_zero@%0d got=%b want=%b", edge_n, ZERO, exp_zero); end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_shift();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_rot();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
